// File: rtl/mem_mfc_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mem_mfc_ctrl
// Byte-addressed data memory behind a 4-phase MFA/MFC handshake with
// programmable wait states. Optional macro MEM_SIGN_EXT_EN adds the SE input
// for sign-extended byte/halfword reads.
// Rev    : 1.0  initial release
// ============================================================================
module mem_mfc_ctrl #(
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic        MFA,
    input  logic        RW,
    input  logic [1:0]  MAS,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
`ifdef MEM_SIGN_EXT_EN
    input  logic        SE,
`endif
    output logic [31:0] data_out,
    output logic        MFC,
    output logic        ERR
);

    localparam int         AW        = $clog2(DEPTH_BYTES);
    localparam logic [1:0] MAS_BYTE  = 2'b00;
    localparam logic [1:0] MAS_WORD  = 2'b01;
    localparam logic [1:0] MAS_HALF  = 2'b10;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      wait_cnt;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            rw_q;
    logic [1:0]      mas_q;
    logic            se_q;

    logic [7:0]      mem [DEPTH_BYTES];

    logic [AW-1:0]   idx1;
    logic [AW-1:0]   idx2;
    logic [AW-1:0]   idx3;
    logic [7:0]      b0;
    logic [7:0]      b1;
    logic [7:0]      b2;
    logic [7:0]      b3;
    logic            legal;
    logic            access;
    logic            do_write;
    logic [31:0]     rdata;
    logic            unused_addr;

    // Upper address bits are ignored so accesses wrap modulo DEPTH_BYTES.
    assign unused_addr = ^addr[31:AW];

    assign idx1 = addr_q + AW'(1);
    assign idx2 = addr_q + AW'(2);
    assign idx3 = addr_q + AW'(3);

    assign b0 = mem[addr_q];
    assign b1 = mem[idx1];
    assign b2 = mem[idx2];
    assign b3 = mem[idx3];

    always_comb begin
        case (mas_q)
            MAS_BYTE: legal = 1'b1;
            MAS_WORD: legal = (addr_q[1:0] == 2'b00);
            MAS_HALF: legal = ~addr_q[0];
            default:  legal = 1'b0;
        endcase
    end

    always_comb begin
        rdata = {b3, b2, b1, b0};
        case (mas_q)
            MAS_BYTE: rdata = {{24{se_q & b0[7]}}, b0};
            MAS_HALF: rdata = {{16{se_q & b1[7]}}, b1, b0};
            default:  ;
        endcase
    end

    assign access   = (state == BUSY) && MFA && (wait_cnt == 4'd0);
    assign do_write = access && legal && rw_q && CLR;

    // Array is never reset; contents survive CLR.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[addr_q] <= wdata_q[7:0];
            if (mas_q != MAS_BYTE) begin
                mem[idx1] <= wdata_q[15:8];
            end
            if (mas_q == MAS_WORD) begin
                mem[idx2] <= wdata_q[23:16];
                mem[idx3] <= wdata_q[31:24];
            end
        end
    end

`ifndef MEM_SIGN_EXT_EN
    assign se_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rw_q     <= 1'b0;
            mas_q    <= 2'b00;
`ifdef MEM_SIGN_EXT_EN
            se_q     <= 1'b0;
`endif
            data_out <= 32'd0;
            MFC      <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MFA) begin
                        addr_q   <= addr[AW-1:0];
                        wdata_q  <= data_in;
                        rw_q     <= RW;
                        mas_q    <= MAS;
`ifdef MEM_SIGN_EXT_EN
                        se_q     <= SE;
`endif
                        wait_cnt <= WAIT_INIT;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!MFA) begin
                        state <= IDLE;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        MFC   <= 1'b1;
                        ERR   <= ~legal;
                        if (legal && !rw_q) begin
                            data_out <= rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Leaving only on MFA low enforces the 4-phase handshake.
                    if (!MFA) begin
                        MFC   <= 1'b0;
                        ERR   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    MFC   <= 1'b0;
                    ERR   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_mfc_ctrl.md
Name: mem_mfc_ctrl

Overview:
- Data memory with a handshake controller, directly downstream of the microprogrammed control unit.
- Consumes the control word fields MFA, R/W and MAS, together with MAR/MDR contents; performs a byte, halfword or word access into an internal byte-addressed array.
- Returns MFC, which the control unit's 1-bit condition mux waits on.
- The 4-phase handshake with programmable wait states lets the microsequencer stall in a "wait for MFC" state.

Parameters:
- DEPTH_BYTES, 256, size of internal byte array; must be a power of two, minimum 4.
- WAIT_STATES, 2, extra cycles between request capture and access, range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- CLR  input  1  reset, asynchronous, active-low.
- MFA  input  1  memory function activate (request), level.
- RW  input  1  0 = read, 1 = write.
- MAS  input  2  access size: 00 byte, 01 word, 10 halfword, 11 reserved.
- addr  input  32  byte address (MAR); only low log2(DEPTH_BYTES) bits are used, so access wraps modulo DEPTH_BYTES.
- data_in  input  32  write data (MDR).
- data_out  output  32  read data, held until next successful read.
- MFC  output  1  memory function complete.
- ERR  output  1  alignment/size error flag for the current completed transaction.

Behaviour:
- Reset (CLR=0, async):
  - state = IDLE; MFC = 0; ERR = 0; data_out = 0; wait counter = 0.
  - Array contents are not cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On a rising edge with MFA=1: capture addr, data_in, RW, MAS into internal registers; load counter = WAIT_STATES; go to BUSY.
  - Inputs are ignored after capture.
- BUSY:
  - If MFA=0 at an edge: abort; go to IDLE; no array write; data_out unchanged; MFC stays 0.
  - Else if counter != 0: decrement the counter.
  - Else (counter == 0): perform the access, set MFC=1, go to DONE.
- Latency: MFC rises on the (WAIT_STATES+1)th rising edge after the capture edge (3 edges for the default).
- DONE:
  - MFC and ERR are held while MFA=1.
  - On the first edge with MFA=0: MFC=0, ERR=0, go to IDLE.
  - A new request needs MFA low for at least one edge (4-phase handshake); MFA held high never re-triggers.
- Byte order: little-endian. Word at A = {mem[A+3], mem[A+2], mem[A+1], mem[A]}. Halfword at A = {mem[A+1], mem[A]}.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Byte is always legal.
- Misaligned access or MAS=11:
  - No array write; data_out unchanged.
  - The transaction still completes (MFC=1) with ERR=1, so the sequencer never hangs.
- Read:
  - data_out is updated on the completion edge.
  - Byte and halfword reads are zero-extended to 32 bits.
- Write:
  - Byte writes data_in[7:0]; halfword writes data_in[15:0]; word writes data_in[31:0].
  - Only the addressed bytes change.
- Wrap: the address index is masked to DEPTH_BYTES-1; a word at an aligned top address never straddles the end.
- CLR asserted mid-transaction: the FSM returns to IDLE immediately and MFC drops. A write not yet performed is lost; an already-written array is untouched.

Optional Feature:
- Macro: MEM_SIGN_EXT_EN.
- When defined:
  - Adds input port SE (1 bit), captured with the request in IDLE.
  - Byte and halfword reads with SE=1 are sign-extended from bit 7 or bit 15.
  - Word reads, writes, and reads with SE=0 are unaffected.
- When undefined: the SE port is absent and all sub-word reads are zero-extended.

Test Plan:
- Word write, then read: write addr=0x10, data_in=0xDEADBEEF, MAS=01, RW=1, then read at 0x10 -> MFC rises exactly 3 edges after the capture edge; data_out=0xDEADBEEF; ERR=0.
- Byte/halfword reads of the word at 0x10 (0xDEADBEEF):
  - Byte at 0x11 -> data_out=0x000000BE.
  - Halfword at 0x12 -> data_out=0x0000DEAD.
  - With MEM_SIGN_EXT_EN and SE=1, byte at 0x13 -> 0xFFFFFFDE.
- Misaligned write: word write to 0x21 with 0x12345678 -> MFC=1, ERR=1. Subsequent byte reads of 0x20..0x23 return their prior values.
- Handshake hold and abort:
  - MFA held 1 for 10 cycles after MFC -> MFC stays 1 and no second access occurs.
  - MFA dropped 1 cycle after capture (WAIT_STATES=2) -> MFC never asserts and the target byte is unchanged.
- Wrap and zero-wait configuration: DEPTH_BYTES=256, WAIT_STATES=0; write byte 0xA5 at addr 0x100 -> read at 0x00 returns 0x000000A5; MFC rises 1 edge after capture.
- Async reset: CLR pulsed low while in DONE with MFC=1 -> MFC, ERR and data_out go to 0 without a clock edge. The next request completes normally.
